fetch_unit: RTL

Instruction-fetch front end for the single-cycle/pipelined LEGv8 core. It owns the program counter and drives the address port of the combinational 64-word instruction memory `imem`. It registers the returned 32-bit word, together with its PC, into an IF/ID output register. It handles stall, branch redirect, alignment/range faults and an optional halt detector.

---
 rtl/fetch_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, addresses the 64-word imem and registers IF/ID.
// Optional halt detection on CBZ XZR,#0 is enabled by defining FETCH_HALT_EN.
module fetch_unit #(
    parameter int N  = 64,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          br_taken,
    input  logic [N-1:0]  br_target,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_q,
    output logic [31:0]   instr,
    output logic [N-1:0]  pc_out,
    output logic          instr_valid,
    output logic          fault,
    output logic          halted
);

`ifdef FETCH_HALT_EN
    typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;
    localparam logic [31:0] HALT_WORD = 32'hB400001F;
`else
    typedef enum logic [1:0] {RUN, FAULT} state_t;
`endif

    state_t        state, state_nx;
    logic [N-1:0]  pc_p0, pc_nx, pc_cand;
    logic [31:0]   instr_nx;
    logic [N-1:0]  pc_out_nx;
    logic          vld_nx;

    // Word-aligned and inside the 2**AW-word memory; anything above is a fault, never a wrap.
    function automatic logic addr_bad(input logic [N-1:0] a);
        return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != '0);
    endfunction

    assign imem_addr = pc_p0[AW+1:2];
    assign fault     = (state == FAULT);
`ifdef FETCH_HALT_EN
    assign halted    = (state == HALT);
`else
    assign halted    = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        pc_nx     = pc_p0;
        instr_nx  = instr;
        pc_out_nx = pc_out;
        vld_nx    = instr_valid;
        pc_cand   = br_taken ? br_target : pc_p0 + N'(4);

        case (state)
            RUN: begin
                if (br_taken || !stall) begin
`ifdef FETCH_HALT_EN
                    if (!br_taken && imem_q == HALT_WORD) begin
                        instr_nx  = imem_q;
                        pc_out_nx = pc_p0;
                        vld_nx    = 1'b1;
                        state_nx  = HALT;
                    end else
`endif
                    if (addr_bad(pc_cand)) begin
                        state_nx = FAULT;
                        vld_nx   = 1'b0;
                    end else begin
                        pc_nx = pc_cand;
                        if (br_taken) begin
                            vld_nx = 1'b0;
                        end else begin
                            instr_nx  = imem_q;
                            pc_out_nx = pc_p0;
                            vld_nx    = 1'b1;
                        end
                    end
                end
            end
            default: vld_nx = 1'b0;
        endcase
    end

    // IF stage boundary: PC register and IF/ID output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            pc_p0       <= '0;
            instr       <= '0;
            pc_out      <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            pc_p0       <= pc_nx;
            instr       <= instr_nx;
            pc_out      <= pc_out_nx;
            instr_valid <= vld_nx;
        end
    end

endmodule
